// File: rtl/mem_line_sched.sv
// mem_line_sched: shares one single-port memory between the ring FIFOs and
// a DMA port, granting whole lines as 8-beat read or write bursts.
module mem_line_sched #(
  parameter int MBITS = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ring_addr_empty,
  input  logic [31:0]      ring_addr,
  input  logic [3:0]       ring_dest,
  output logic             ring_addr_rd,
  input  logic             ring_wd_empty,
  input  logic [31:0]      ring_wd,
  output logic             ring_wd_rd,
  input  logic             dma_req,
  input  logic             dma_write,
  input  logic [MBITS-4:0] dma_line,
  output logic             dma_grant,
  input  logic [31:0]      dma_wd,
  output logic             dma_wd_rd,
  output logic [31:0]      dma_rdata,
  output logic             dma_rvalid,
  output logic             mem_en,
  output logic             mem_we,
  output logic [MBITS-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      rd_return,
  output logic [3:0]       rd_dest,
  output logic             busy,
  output logic             bad_addr
);

  localparam int LW = MBITS - 3;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t        state, state_nx;
  logic [2:0]    beat, beat_nx;
  logic [LW-1:0] line, line_nx;
  logic          owner_dma, owner_nx;
  logic [3:0]    dest, dest_nx;
  logic          last_dma, last_nx;
  logic          ret_ring, ret_dma;
  logic [3:0]    ret_dest;
  logic          ring_ok, ring_bad;
  logic          take_ring, take_dma;
  logic          rd_issue, adv;
  logic          unused_hi;

  assign unused_hi = ^ring_addr[31:29];

  assign ring_ok  = ~ring_addr_empty & (ring_addr[27:LW] == '0);
  assign ring_bad = ~ring_addr_empty & ~ring_ok;

  // round-robin: ring wins a tie unless it took the previous grant
  assign take_ring = ring_ok & (~dma_req | last_dma);
  assign take_dma  = dma_req & ~ring_bad & ~take_ring;

  always_comb begin
    state_nx     = state;
    beat_nx      = beat;
    line_nx      = line;
    owner_nx     = owner_dma;
    dest_nx      = dest;
    last_nx      = last_dma;
    ring_addr_rd = 1'b0;
    ring_wd_rd   = 1'b0;
    dma_grant    = 1'b0;
    dma_wd_rd    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    bad_addr     = 1'b0;
    rd_issue     = 1'b0;
    adv          = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (ring_bad) begin
            ring_addr_rd = 1'b1;
            bad_addr     = 1'b1;
          end else if (take_ring) begin
            ring_addr_rd = 1'b1;
            line_nx      = ring_addr[LW-1:0];
            owner_nx     = 1'b0;
            dest_nx      = ring_dest;
            last_nx      = 1'b0;
            beat_nx      = '0;
            state_nx     = ring_addr[28] ? RD_BURST : WR_BURST;
          end else if (take_dma) begin
            dma_grant = 1'b1;
            line_nx   = dma_line;
            owner_nx  = 1'b1;
            dest_nx   = '0;
            last_nx   = 1'b1;
            beat_nx   = '0;
            state_nx  = dma_write ? WR_BURST : RD_BURST;
          end
        end
        RD_BURST: begin
          mem_en   = 1'b1;
          rd_issue = 1'b1;
          beat_nx  = beat + 3'd1;
          if (beat == 3'd7) state_nx = IDLE;
        end
        WR_BURST: begin
          adv = owner_dma | ~ring_wd_empty;
          if (adv) begin
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_wdata  = owner_dma ? dma_wd : ring_wd;
            dma_wd_rd  = owner_dma;
            ring_wd_rd = ~owner_dma;
            beat_nx    = beat + 3'd1;
            if (beat == 3'd7) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      line      <= '0;
      owner_dma <= 1'b0;
      dest      <= '0;
      last_dma  <= 1'b1;
      ret_ring  <= 1'b0;
      ret_dma   <= 1'b0;
      ret_dest  <= '0;
    end else begin
      state     <= state_nx;
      beat      <= beat_nx;
      line      <= line_nx;
      owner_dma <= owner_nx;
      dest      <= dest_nx;
      last_dma  <= last_nx;
      ret_ring  <= rd_issue & ~owner_dma;
      ret_dma   <= rd_issue & owner_dma;
      ret_dest  <= (rd_issue & ~owner_dma) ? dest : 4'd0;
    end
  end

  assign mem_addr   = {line, beat};
  assign rd_dest    = ret_dest;
  assign rd_return  = ret_ring ? mem_rdata : '0;
  assign dma_rvalid = ret_dma;
  assign dma_rdata  = ret_dma ? mem_rdata : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_line_sched.sv
// tb_mem_line_sched: table vectors, directed bursts and random traffic
// checked against a transaction-level model of the line scheduler.
module tb_mem_line_sched;
  localparam int MBITS = 24;
  localparam int LW = MBITS - 3;

  logic clock = 0, reset = 1;
  logic ring_addr_empty, ring_addr_rd, ring_wd_empty, ring_wd_rd;
  logic [31:0] ring_addr, ring_wd, dma_wd, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0, rd_return;
  logic [3:0] ring_dest, rd_dest;
  logic dma_req, dma_write, dma_grant, dma_wd_rd, dma_rvalid;
  logic [LW-1:0] dma_line;
  logic mem_en, mem_we, busy, bad_addr;
  logic [MBITS-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_line_sched #(.MBITS(MBITS)) dut (
    .clock(clock), .reset(reset),
    .ring_addr_empty(ring_addr_empty), .ring_addr(ring_addr),
    .ring_dest(ring_dest), .ring_addr_rd(ring_addr_rd),
    .ring_wd_empty(ring_wd_empty), .ring_wd(ring_wd),
    .ring_wd_rd(ring_wd_rd), .dma_req(dma_req),
    .dma_write(dma_write), .dma_line(dma_line),
    .dma_grant(dma_grant), .dma_wd(dma_wd), .dma_wd_rd(dma_wd_rd),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_return(rd_return), .rd_dest(rd_dest), .busy(busy),
    .bad_addr(bad_addr));

  typedef struct packed { logic [31:0] a; logic [3:0] d; } rreq_t;
  typedef struct packed { logic w; logic [LW-1:0] l; } dreq_t;
  typedef struct packed {
    logic v; logic dma; logic [3:0] dest; logic [31:0] val;
  } ret_t;
  typedef struct { int c; logic [3:0] d; logic [31:0] v; } log_t;
  typedef struct {
    bit re; logic [31:0] ra; bit dr; bit dw; logic [2:0] e;
  } tv_t;

  rreq_t raq[$];
  logic [31:0] wdq[$];
  dreq_t dq[$];
  logic [31:0] phys[int];
  logic [31:0] refm[int];
  ret_t sched[4];
  log_t rlog[$];
  int pop_cyc[$], dgr_cyc[$];
  tv_t tv[8];

  int n_vec = 0, n_bad = 0, cyc = 0;
  int m_left = 0;
  bit m_last_dma = 1, m_dma = 0, m_wr = 0;
  logic [LW-1:0] m_line = 0;
  logic [3:0] m_dest = 0;
  int wd_block = 0, wd_gap_at = -1;
  int n_wdpop = 0, n_pop = 0, n_badp = 0, n_we = 0, n_dv = 0;
  bit rd_pend = 0;
  logic [7:0] s_ctl;
  logic [MBITS-1:0] s_addr;
  logic [3:0] s_rdest;
  logic [31:0] ra;

  function automatic logic [31:0] initv(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  function automatic logic [31:0] physget(int a);
    return phys.exists(a) ? phys[a] : initv(a);
  endfunction
  function automatic logic [31:0] refget(int a);
    return refm.exists(a) ? refm[a] : initv(a);
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic push_ring(logic [31:0] a, logic [3:0] d);
    rreq_t r;
    r.a = a; r.d = d;
    raq.push_back(r);
  endtask
  task automatic push_dma(logic w, logic [LW-1:0] l);
    dreq_t r;
    r.w = w; r.l = l;
    dq.push_back(r);
  endtask

  task automatic drive();
    ring_addr_empty = (raq.size() == 0);
    ring_addr = (raq.size() > 0) ? raq[0].a : 32'h0;
    ring_dest = (raq.size() > 0) ? raq[0].d : 4'h0;
    ring_wd_empty = (wdq.size() == 0) || (wd_block > 0);
    ring_wd = (wdq.size() > 0) ? wdq[0] : $urandom;
    dma_req = (dq.size() > 0);
    dma_write = (dq.size() > 0) ? dq[0].w : 1'b0;
    dma_line = (dq.size() > 0) ? dq[0].l : '0;
    dma_wd = $urandom;
  endtask

  // reference: one line transaction at a time, 8 beats, returns 1 cycle late
  task automatic model();
    logic [7:0] e_ctl;
    logic [MBITS-1:0] ea;
    logic [31:0] ew;
    ret_t r;
    bit cand, bad;
    r = sched[cyc % 4];
    sched[cyc % 4] = '0;
    chk("rd_dest", {60'd0, rd_dest}, (r.v && !r.dma) ? {60'd0, r.dest} : 64'd0);
    if (r.v && !r.dma) chk("rd_return", {32'd0, rd_return}, {32'd0, r.val});
    chk("dma_rvalid", {63'd0, dma_rvalid}, {63'd0, r.v && r.dma});
    if (r.v && r.dma) chk("dma_rdata", {32'd0, dma_rdata}, {32'd0, r.val});
    e_ctl = 8'h00;
    ew = 32'h0;
    ea = {m_line, 3'(8 - m_left)};
    if (m_left == 0) begin
      cand = !ring_addr_empty && (ring_addr[27:LW] == 0);
      bad = !ring_addr_empty && !cand;
      if (bad) e_ctl = 8'b1000_0010;
      else if (cand && (!dma_req || m_last_dma)) begin
        e_ctl = 8'b1000_0000;
        m_last_dma = 0; m_dma = 0; m_wr = !ring_addr[28];
        m_line = ring_addr[LW-1:0]; m_dest = ring_dest; m_left = 8;
      end else if (dma_req) begin
        e_ctl = 8'b0010_0000;
        m_last_dma = 1; m_dma = 1; m_wr = dma_write;
        m_line = dma_line; m_left = 8;
      end
    end else begin
      e_ctl = 8'b0000_0001;
      if (!m_wr) begin
        e_ctl = 8'b0000_1001;
        sched[(cyc + 1) % 4] = {1'b1, m_dma, m_dest, refget(int'(ea))};
        m_left--;
      end else if (m_dma) begin
        e_ctl = 8'b0001_1101; ew = dma_wd;
      end else if (!ring_wd_empty) begin
        e_ctl = 8'b0100_1101; ew = ring_wd;
      end
      if (m_wr && e_ctl[3]) begin
        refm[int'(ea)] = ew;
        m_left--;
      end
    end
    chk("ctl", {56'd0, s_ctl}, {56'd0, e_ctl});
    if (e_ctl[3]) chk("mem_addr", {40'd0, mem_addr}, {40'd0, ea});
    if (e_ctl[2]) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, ew});
  endtask

  task automatic step();
    @(negedge clock);
    s_ctl = {ring_addr_rd, ring_wd_rd, dma_grant, dma_wd_rd,
             mem_en, mem_we, bad_addr, busy};
    s_addr = mem_addr;
    s_rdest = rd_dest;
    if (reset) begin
      m_left = 0; m_last_dma = 1;
      for (int i = 0; i < 4; i++) sched[i] = '0;
    end else model();
    if (wd_block > 0) wd_block--;
    rd_pend = mem_en && !mem_we;
    if (mem_en && mem_we) begin
      phys[int'(mem_addr)] = mem_wdata;
      n_we++;
    end
    if (ring_addr_rd && raq.size() > 0) begin
      raq.delete(0); n_pop++; pop_cyc.push_back(cyc);
    end
    if (ring_wd_rd && wdq.size() > 0) begin
      wdq.delete(0); n_wdpop++;
      if (n_wdpop == wd_gap_at) wd_block = 3;
    end
    if (dma_grant && dq.size() > 0) begin
      dq.delete(0); dgr_cyc.push_back(cyc);
    end
    if (bad_addr) n_badp++;
    if (dma_rvalid) n_dv++;
    if (rd_dest != 0) rlog.push_back('{cyc, rd_dest, rd_return});
    @(posedge clock);
    #1;
    cyc++;
    mem_rdata = rd_pend ? physget(int'(s_addr)) : $urandom;
    drive();
  endtask

  task automatic do_reset(int n);
    raq.delete(); wdq.delete(); dq.delete();
    wd_block = 0; wd_gap_at = -1;
    reset = 1;
    drive();
    repeat (n) step();
    reset = 0;
  endtask

  task automatic drain(int lim);
    int k = 0;
    while ((m_left > 0 || raq.size() > 0 || dq.size() > 0) && k < lim) begin
      step();
      k++;
    end
    chk("drain_bound", {63'd0, k < lim}, 64'd1);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit eb;
    int k;
    // e = {pop, grant, bad} in the first idle cycle after reset
    tv[0] = '{1, 32'h0000_0000, 0, 0, 3'b000};
    tv[1] = '{0, 32'h1000_0005, 0, 0, 3'b100};
    tv[2] = '{0, 32'h0000_0005, 0, 0, 3'b100};
    tv[3] = '{1, 32'h0000_0000, 1, 1, 3'b010};
    tv[4] = '{0, 32'h1000_0005, 1, 0, 3'b100};
    tv[5] = '{0, 32'h1020_0000, 0, 0, 3'b101};
    tv[6] = '{0, 32'h1020_0000, 1, 1, 3'b101};
    tv[7] = '{0, 32'h0800_0000, 1, 0, 3'b101};
    drive();
    do_reset(3);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rd_dest", {60'd0, rd_dest}, 64'd0);
    chk("reset_mem_en", {63'd0, mem_en}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset(2);
      if (!tv[i].re) push_ring(tv[i].ra, 4'd1);
      if (tv[i].dr) push_dma(tv[i].dw, 21'd6);
      drive();
      step();
      chk("tv_arb", {61'd0, s_ctl[7], s_ctl[5], s_ctl[1]}, {61'd0, tv[i].e});
      eb = (tv[i].e[2] && !tv[i].e[0]) || tv[i].e[1];
      step();
      chk("tv_busy", {63'd0, s_ctl[0]}, {63'd0, eb});
    end

    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      phys[32'h100 + i] = 32'hA0 + i;
      refm[32'h100 + i] = 32'hA0 + i;
    end
    push_ring(32'h1000_0020, 4'd3);
    rlog.delete(); pop_cyc.delete();
    drive();
    drain(40);
    chk("rr_count", 64'(rlog.size()), 64'd8);
    for (int i = 0; i < rlog.size() && i < 8 && pop_cyc.size() > 0; i++) begin
      chk("rr_data", {32'd0, rlog[i].v}, 64'(32'hA0 + i));
      chk("rr_time", 64'(rlog[i].c - pop_cyc[0]), 64'(2 + i));
    end

    do_reset(2);
    push_ring(32'h0000_0021, 4'd1);
    for (int i = 1; i <= 8; i++) wdq.push_back(32'(i));
    wd_gap_at = 4; n_we = 0; n_wdpop = 0;
    drive();
    drain(40);
    for (int i = 0; i < 8; i++)
      chk("wr_mem", {32'd0, physget(32'h108 + i)}, 64'(i + 1));
    chk("wr_we", 64'(n_we), 64'd8);
    chk("wr_pops", 64'(n_wdpop), 64'd8);

    do_reset(2);
    push_ring(32'h1000_0005, 4'd2); push_ring(32'h1000_0005, 4'd2);
    push_dma(1, 21'd6); push_dma(1, 21'd6);
    pop_cyc.delete(); dgr_cyc.delete();
    drive();
    drain(80);
    chk("sim_grants", 64'(pop_cyc.size() + dgr_cyc.size()), 64'd4);
    if (pop_cyc.size() > 1 && dgr_cyc.size() > 0) begin
      chk("sim_ring_dma", 64'(dgr_cyc[0] - pop_cyc[0]), 64'd9);
      chk("sim_dma_ring", 64'(pop_cyc[1] - dgr_cyc[0]), 64'd9);
    end

    do_reset(2);
    push_dma(0, 21'd7);
    n_dv = 0; rlog.delete();
    drive();
    drain(40);
    chk("dr_valid", 64'(n_dv), 64'd8);
    chk("dr_rdest", 64'(rlog.size()), 64'd0);

    do_reset(2);
    push_ring(32'h1020_0000, 4'd4); push_ring(32'h1000_0009, 4'd2);
    n_badp = 0; n_pop = 0; rlog.delete();
    drive();
    drain(40);
    chk("oor_bad", 64'(n_badp), 64'd1);
    chk("oor_pops", 64'(n_pop), 64'd2);
    chk("oor_served", 64'(rlog.size()), 64'd8);

    do_reset(2);
    push_ring(32'h1000_0030, 4'd5);
    drive();
    k = 0;
    step();
    while (!(s_ctl[3] && s_addr[2:0] == 3'd3) && k < 30) begin
      step();
      k++;
    end
    chk("rst_reach_beat3", {63'd0, k < 30}, 64'd1);
    n_pop = 0;
    reset = 1;
    step();
    chk("rst_memen_during", {63'd0, s_ctl[3]}, 64'd0);
    reset = 0;
    step();
    chk("rst_rdest", {60'd0, s_rdest}, 64'd0);
    chk("rst_memen", {63'd0, s_ctl[3]}, 64'd0);
    chk("rst_busy", {63'd0, s_ctl[0]}, 64'd0);
    repeat (4) step();
    chk("rst_pops", 64'(n_pop), 64'd0);

    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 2 && raq.size() < 4) begin
        ra = {3'b0, 1'($urandom),
              7'(($urandom_range(0, 15) == 0) ? $urandom_range(1, 127) : 0),
              21'($urandom_range(0, 15))};
        push_ring(ra, 4'($urandom_range(1, 15)));
      end
      if ($urandom_range(0, 9) < 6) wdq.push_back($urandom);
      if ($urandom_range(0, 19) == 0) wd_block = 2;
      if ($urandom_range(0, 9) == 0 && dq.size() < 2)
        push_dma(1'($urandom), 21'($urandom_range(0, 15)));
      drive();
      step();
    end
    repeat (200) wdq.push_back($urandom);
    drive();
    drain(600);
    foreach (refm[a]) chk("final_mem", {32'd0, physget(a)}, {32'd0, refm[a]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_line_sched.md
Name: mem_line_sched

Overview:
- Scheduler that shares the single-port main-memory array between two requesters: the ring memory-controller FIFOs (address FIFO plus write-data FIFO) and a local DMA/copy-engine port.
- Arbitrates at cache-line granularity and sequences each grant as an 8-beat read or write burst.
- Read data goes back on the pipelined RDreturn/RDdest bus for ring requests, and on a dedicated return path for DMA requests.

Parameters:
- MBITS, 24, log2 of memory size in 32-bit words; a line address is MBITS-3 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ring_addr_empty  in  1  ring address FIFO empty
- ring_addr  in  32  FIFO head; bit28=1 read, 0 write; bits[27:0] line address
- ring_dest  in  4  requesting core of the FIFO head
- ring_addr_rd  out  1  pop ring address FIFO
- ring_wd_empty  in  1  ring write-data FIFO empty
- ring_wd  in  32  write-data FIFO head
- ring_wd_rd  out  1  pop write-data FIFO
- dma_req  in  1  DMA request; held until granted
- dma_write  in  1  1 = write line, 0 = read line
- dma_line  in  MBITS-3  DMA line address
- dma_grant  out  1  1-cycle pulse when the DMA request is accepted
- dma_wd  in  32  DMA write word, combinational on dma_wd_rd
- dma_wd_rd  out  1  DMA write word consumed this cycle
- dma_rdata  out  32  DMA read word
- dma_rvalid  out  1  dma_rdata valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  MBITS  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid 1 cycle after mem_en & ~mem_we
- rd_return  out  32  ring read-return word
- rd_dest  out  4  ring read-return destination; 0 = idle
- busy  out  1  state != IDLE
- bad_addr  out  1  1-cycle pulse on a dropped out-of-range ring request

Behaviour:
- Reset values:
  - State = IDLE, beat counter = 0, last_grant = DMA (so the ring wins the first tie).
  - All outputs 0: rd_dest = 0, dma_rvalid = 0, mem_en = 0.
- Reset mid-burst abandons the burst immediately:
  - No further pops or memory accesses.
  - The read-return pipeline is cleared on the same edge.
- States: IDLE, RD_BURST, WR_BURST. Latched per burst: line, owner (RING/DMA), dest.
- IDLE, ring candidate: ~ring_addr_empty with ring_addr[27:MBITS-3]==0.
- IDLE, out-of-range ring head:
  - Popped and dropped in one cycle (ring_addr_rd=1, bad_addr=1); no burst starts.
  - No other grant that cycle.
- IDLE, arbitration:
  - One candidate: it wins.
  - Both: the requester that is not last_grant wins (round-robin).
- IDLE, on a grant:
  - Ring grant: ring_addr_rd=1 that cycle.
  - DMA grant: dma_grant=1 that cycle.
  - last_grant is updated, the counter cleared, and the next state is RD_BURST or WR_BURST.
  - No memory access in the grant cycle.
- RD_BURST:
  - Every cycle issues mem_en=1, mem_we=0, mem_addr={line, beat[2:0]}.
  - Beat increments; after beat 7 the next state is IDLE.
  - Next cycle: owner RING gives rd_return=mem_rdata and rd_dest=dest; owner DMA gives dma_rdata=mem_rdata and dma_rvalid=1.
  - Exactly 8 consecutive return cycles, in beat order 0..7.
  - The 8th return overlaps the following IDLE/grant cycle.
- WR_BURST, ring owner:
  - Beat advances only when ~ring_wd_empty.
  - On an advance: ring_wd_rd=1, mem_en=1, mem_we=1, mem_wdata=ring_wd.
  - If ring_wd_empty: stall with no access and the counter held, for any number of cycles.
- WR_BURST, DMA owner: advances every cycle, with dma_wd_rd=1 and mem_wdata=dma_wd.
- WR_BURST exit: after beat 7 is written, the next state is IDLE.
- Grant-to-grant minimum spacing is 9 cycles (1 grant + 8 beats).
- Busy is asserted from the cycle after the grant until the cycle after the last beat.
- A DMA request deasserted before its grant is simply not served; dma_grant never fires without dma_req.
- Write-then-read ordering: accesses are strictly sequential, so a read granted after a write to the same line returns the new data.

Test Plan:
- Ring read:
  - Stimulus: mem[0x100..0x107]=i+0xA0, ring_addr=0x1000_0020, ring_dest=3.
  - Required: 8 cycles of rd_dest=3 with rd_return=0xA0..0xA7, in order, starting 2 cycles after the pop.
- Ring write with gappy data:
  - Stimulus: addr 0x0000_0021, data words 1..8 pushed with ring_wd_empty high for 3 cycles after word 4.
  - Required: mem[0x108..0x10F]=1..8; 8 mem_we pulses and exactly 8 ring_wd_rd pulses.
- Simultaneous requests:
  - Stimulus: ring read line 5 and DMA write line 6 both pending after reset.
  - Required: ring granted first, dma_grant 9 cycles later; with both held again, the ring is granted 9 cycles after that.
- DMA read:
  - Stimulus: dma_line=7, read.
  - Required: dma_rvalid for 8 cycles; rd_dest stays 0 throughout.
- Out-of-range:
  - Stimulus: ring_addr=0x1020_0000 with MBITS=24.
  - Required: bad_addr pulse, a single pop, no mem_en; the next valid request is then served normally.
- Reset mid-read:
  - Stimulus: reset asserted at beat 3 of a ring read.
  - Required: rd_dest=0 and mem_en=0 on the next cycle, busy=0, and no additional FIFO pops.
